// File: rtl/sine_cos_pwm_pkg.sv
// Shared constants and types for the dual-channel sine/cos PWM modulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sine_cos_pkg;

  // Default sample width and PWM resolution.
  localparam int WIDTH_DEF = 8;

  // Full-scale duty; a period spans this many counter ticks.
  function automatic int pwm_max(input int width);
    return (1 << width) - 1;
  endfunction

  // Modulator FSM encoding.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sine_cos_pwm_if.sv
// Sample/strobe/PWM bundle between the sine/cos generator and the modulator.
// Latency: n/a (wiring only).
// Backpressure: none; sample_req paces the generator, one step per PWM period.
interface sine_cos_pwm_if
  import sine_cos_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             en;
  logic [WIDTH-1:0] sine_u;
  logic [WIDTH-1:0] cos_u;
  logic             sample_req;
  logic             period_start;
  logic             pwm_sine;
  logic             pwm_cos;

  // Generator/controller side.
  modport master (
    output en, sine_u, cos_u,
    input  sample_req, period_start, pwm_sine, pwm_cos
  );

  // Modulator side.
  modport slave (
    input  en, sine_u, cos_u,
    output sample_req, period_start, pwm_sine, pwm_cos
  );

endinterface

// File: rtl/sine_cos_pwm_chan.sv
// One PWM channel: double-buffered duty register plus registered compare.
// Latency: 1 clk from counter/duty to o_pwm.
// Backpressure: none; i_din is only sampled on i_load.
module sine_cos_pwm_chan
  import sine_cos_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_active,
  input  logic [WIDTH-1:0] i_din,
  input  logic [WIDTH-1:0] i_cnt,
  output logic             o_pwm
);

  logic [WIDTH-1:0] r_duty;
  logic             r_pwm;

  // Duty only changes at a period boundary so a period is never split.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_duty <= '0;
    end else if (i_load) begin
      r_duty <= i_din;
    end
  end

  // Output is high while the shared counter is below the duty; forced low when not running.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= i_active && (i_cnt < r_duty);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/sine_cos_pwm.sv
// Dual PWM modulator for offset-binary sine/cos samples; strobes the generator once per period.
// Latency: load edge -> period_start +1 clk, sample_req +2 clk; counter/duty -> pwm pins 1 clk.
// Backpressure: none; en low idles the block, duty registers hold.
module sine_cos_pwm
  import sine_cos_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int PRESCALE = 1
) (
  input  logic          clk,
  input  logic          reset,
  sine_cos_pwm_if.slave bus
);

  localparam int                MAX      = pwm_max(WIDTH);
  localparam int                PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0]  CNT_LAST = WIDTH'(MAX - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PRE_W-1:0] r_pre;
  logic [WIDTH-1:0] r_cnt;
  logic             r_period_start;
  logic             r_sample_req;
  logic             w_tick;
  logic             w_load;
  logic             w_active;
  logic             w_pwm_s;
  logic             w_pwm_c;

  assign w_tick = (r_pre == PRE_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, duty-load strobe and run qualifier; en low always wins over a wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_active    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.en) begin
          w_state_nxt = RUN;
          w_load      = 1'b1;
        end
      end
      RUN: begin
        if (!bus.en) begin
          w_state_nxt = IDLE;
        end else begin
          w_active = 1'b1;
          w_load   = w_tick && (r_cnt == CNT_LAST);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Prescaler and period counter; cleared when idle and at every load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (w_active && !w_load) begin
      if (w_tick) begin
        r_pre <= '0;
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end else begin
      r_pre <= '0;
      r_cnt <= '0;
    end
  end

  // period_start marks the load; sample_req trails it by a clk so the generator steps after the load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_period_start <= 1'b0;
      r_sample_req   <= 1'b0;
    end else begin
      r_period_start <= w_load;
      r_sample_req   <= bus.en && r_period_start;
    end
  end

  sine_cos_pwm_chan #(.WIDTH(WIDTH)) u_chan_s (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_active (w_active),
    .i_din    (bus.sine_u),
    .i_cnt    (r_cnt),
    .o_pwm    (w_pwm_s)
  );

  sine_cos_pwm_chan #(.WIDTH(WIDTH)) u_chan_c (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_active (w_active),
    .i_din    (bus.cos_u),
    .i_cnt    (r_cnt),
    .o_pwm    (w_pwm_c)
  );

  assign bus.pwm_sine     = w_pwm_s;
  assign bus.pwm_cos      = w_pwm_c;
  assign bus.period_start = r_period_start;
  assign bus.sample_req   = r_sample_req;

endmodule

// File: tb/tb_sine_cos_pwm.sv
// Bench for sine_cos_pwm: one instance with PRESCALE=1 (a) and one with PRESCALE=4 (b).
// Each period is measured as the window from one sample_req to the next, which lines up
// exactly with the pwm output of the duty loaded just before that sample_req.
module tb_sine_cos_pwm;

  localparam int PMAX = 255;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   gen_steps;

  always #5 clk = ~clk;

  sine_cos_pwm_if #(.WIDTH(8)) if_a ();
  sine_cos_pwm_if #(.WIDTH(8)) if_b ();

  sine_cos_pwm #(.WIDTH(8), .PRESCALE(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  sine_cos_pwm #(.WIDTH(8), .PRESCALE(4)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

  // Generator model: advances one step per sample_req, like the real generator's en.
  always_ff @(posedge clk) begin
    if (reset) gen_steps <= 0;
    else if (if_a.sample_req) gen_steps <= gen_steps + 1;
  end

  function automatic logic sreq(input int w);
    return (w != 0) ? if_b.sample_req : if_a.sample_req;
  endfunction
  function automatic logic pstart(input int w);
    return (w != 0) ? if_b.period_start : if_a.period_start;
  endfunction
  function automatic logic pws(input int w);
    return (w != 0) ? if_b.pwm_sine : if_a.pwm_sine;
  endfunction
  function automatic logic pwc(input int w);
    return (w != 0) ? if_b.pwm_cos : if_a.pwm_cos;
  endfunction

  task automatic set_in(input int w, input logic [7:0] s, input logic [7:0] c);
    if (w != 0) begin if_b.sine_u = s; if_b.cos_u = c; end
    else        begin if_a.sine_u = s; if_a.cos_u = c; end
  endtask

  task automatic wait_sreq(input int w);
    int k = 0;
    while (!sreq(w) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (!sreq(w)) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_sreq[%0d]: no sample_req within %0d clk", w, k);
    end
  endtask

  // Count one window starting at the current sample_req; optionally change sine mid-window.
  task automatic measure(input int w, input int chg_at, input logic [7:0] chg_s,
                         output int hs, output int hc, output int len);
    hs = 0; hc = 0; len = 0;
    do begin
      if (len == chg_at) begin
        if (w != 0) if_b.sine_u = chg_s; else if_a.sine_u = chg_s;
      end
      hs += int'(pws(w));
      hc += int'(pwc(w));
      len++;
      @(negedge clk);
    end while (!sreq(w) && len < 5000);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_a.en = 1'b0; if_b.en = 1'b0;
    set_in(0, 8'h00, 8'h00);
    set_in(1, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({if_a.pwm_sine, if_a.pwm_cos, if_a.period_start, if_a.sample_req} !== 4'b0) begin
      n_bad++; $display("FAIL reset_out_a: got %b want 0000",
        {if_a.pwm_sine, if_a.pwm_cos, if_a.period_start, if_a.sample_req});
    end
    n_cmp++;
    if ({if_b.pwm_sine, if_b.pwm_cos, if_b.period_start, if_b.sample_req} !== 4'b0) begin
      n_bad++; $display("FAIL reset_out_b: got %b want 0000",
        {if_b.pwm_sine, if_b.pwm_cos, if_b.period_start, if_b.sample_req});
    end
    n_cmp++;
    if (dut_a.u_chan_s.r_duty !== 8'h00) begin
      n_bad++; $display("FAIL reset_duty_s: got %h want 00", dut_a.u_chan_s.r_duty);
    end
    n_cmp++;
    if (dut_a.u_chan_c.r_duty !== 8'h00) begin
      n_bad++; $display("FAIL reset_duty_c: got %h want 00", dut_a.u_chan_c.r_duty);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({if_a.pwm_sine, if_a.pwm_cos, if_a.period_start, if_a.sample_req} !== 4'b0) begin
      n_bad++; $display("FAIL idle_out_a: got %b want 0000",
        {if_a.pwm_sine, if_a.pwm_cos, if_a.period_start, if_a.sample_req});
    end
  endtask

  task automatic test_basic();
    int hs, hc, len;
    set_in(0, 8'h40, 8'hC0);
    if_a.en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({if_a.period_start, if_a.sample_req} !== 2'b10) begin
      n_bad++; $display("FAIL start_ps: got ps/sr=%b want 10", {if_a.period_start, if_a.sample_req});
    end
    @(negedge clk);
    n_cmp++;
    if ({if_a.period_start, if_a.sample_req} !== 2'b01) begin
      n_bad++; $display("FAIL start_sr: got ps/sr=%b want 01", {if_a.period_start, if_a.sample_req});
    end
    for (int p = 0; p < 2; p++) begin
      measure(0, -1, 8'h00, hs, hc, len);
      n_cmp++;
      if (hs !== 64) begin n_bad++; $display("FAIL basic_hi_s[%0d]: got %0d want 64", p, hs); end
      n_cmp++;
      if (hc !== 192) begin n_bad++; $display("FAIL basic_hi_c[%0d]: got %0d want 192", p, hc); end
      n_cmp++;
      if (len !== PMAX) begin n_bad++; $display("FAIL basic_len[%0d]: got %0d want %0d", p, len, PMAX); end
    end
  endtask

  task automatic test_extremes();
    int hs, hc, len;
    set_in(0, 8'h00, 8'hFF);
    measure(0, -1, 8'h00, hs, hc, len);
    n_cmp++;
    if (hs !== 64) begin n_bad++; $display("FAIL ext_prev_s: got %0d want 64", hs); end
    for (int p = 0; p < 3; p++) begin
      measure(0, -1, 8'h00, hs, hc, len);
      n_cmp++;
      if (hs !== 0) begin n_bad++; $display("FAIL ext_zero_s[%0d]: got %0d want 0", p, hs); end
      n_cmp++;
      if (hc !== PMAX || len !== PMAX) begin
        n_bad++; $display("FAIL ext_full_c[%0d]: got %0d/%0d want %0d/%0d", p, hc, len, PMAX, PMAX);
      end
    end
  endtask

  task automatic test_midchange(output logic [7:0] cur_s, output logic [7:0] cur_c);
    int hs, hc, len;
    logic [7:0] rc;
    rc = 8'($urandom_range(1, 254));
    set_in(0, 8'h40, rc);
    measure(0, -1, 8'h00, hs, hc, len);
    // sample_req cycle has cnt=1, so change at offset 9 lands on cnt=10
    measure(0, 9, 8'h80, hs, hc, len);
    n_cmp++;
    if (hs !== 64) begin n_bad++; $display("FAIL mid_cur_s: got %0d want 64", hs); end
    n_cmp++;
    if (hc !== int'(rc)) begin n_bad++; $display("FAIL mid_cur_c: got %0d want %0d", hc, rc); end
    measure(0, -1, 8'h00, hs, hc, len);
    n_cmp++;
    if (hs !== 128) begin n_bad++; $display("FAIL mid_next_s: got %0d want 128", hs); end
    cur_s = 8'h80;
    cur_c = rc;
  endtask

  task automatic test_random(input logic [7:0] s0, input logic [7:0] c0);
    int hs, hc, len;
    logic [7:0] cur_s, cur_c, nxt_s, nxt_c;
    cur_s = s0; cur_c = c0;
    for (int p = 0; p < 6; p++) begin
      nxt_s = (p == 2) ? 8'hFF : 8'($urandom);
      nxt_c = (p == 3) ? 8'h00 : 8'($urandom);
      set_in(0, nxt_s, nxt_c);
      measure(0, -1, 8'h00, hs, hc, len);
      n_cmp++;
      if (hs !== int'(cur_s) || hc !== int'(cur_c) || len !== PMAX) begin
        n_bad++;
        $display("FAIL rand[%0d]: got s=%0d c=%0d len=%0d want s=%0d c=%0d len=%0d",
                 p, hs, hc, len, cur_s, cur_c, PMAX);
      end
      cur_s = nxt_s; cur_c = nxt_c;
    end
  endtask

  task automatic test_en_drop();
    int hs, hc, len, seen;
    set_in(0, 8'hFF, 8'hFF);
    measure(0, -1, 8'h00, hs, hc, len);
    repeat (99) @(negedge clk);
    n_cmp++;
    if ({if_a.pwm_sine, if_a.pwm_cos} !== 2'b11) begin
      n_bad++; $display("FAIL drop_pre: got %b want 11", {if_a.pwm_sine, if_a.pwm_cos});
    end
    if_a.en = 1'b0;
    set_in(0, 8'h33, 8'h99);
    @(negedge clk);
    n_cmp++;
    if ({if_a.pwm_sine, if_a.pwm_cos, if_a.period_start, if_a.sample_req} !== 4'b0) begin
      n_bad++; $display("FAIL drop_out: got %b want 0000",
        {if_a.pwm_sine, if_a.pwm_cos, if_a.period_start, if_a.sample_req});
    end
    seen = 0;
    repeat (19) begin
      @(negedge clk);
      seen += int'(if_a.pwm_sine | if_a.pwm_cos | if_a.period_start | if_a.sample_req);
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL drop_idle: got %0d active clk want 0", seen); end
    if_a.en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({if_a.period_start, if_a.sample_req} !== 2'b10) begin
      n_bad++; $display("FAIL raise_ps: got %b want 10", {if_a.period_start, if_a.sample_req});
    end
    @(negedge clk);
    n_cmp++;
    if ({if_a.period_start, if_a.sample_req} !== 2'b01) begin
      n_bad++; $display("FAIL raise_sr: got %b want 01", {if_a.period_start, if_a.sample_req});
    end
    measure(0, -1, 8'h00, hs, hc, len);
    n_cmp++;
    if (hs !== 8'h33 || hc !== 8'h99 || len !== PMAX) begin
      n_bad++; $display("FAIL raise_period: got s=%0d c=%0d len=%0d want 51 153 255", hs, hc, len);
    end
  endtask

  task automatic test_wrap_vs_en();
    int seen;
    // window starts in the second cycle after a load; the wrap edge closes 253 cycles later
    repeat (253) @(negedge clk);
    if_a.en = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(if_a.period_start | if_a.sample_req);
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL wrap_en: got %0d strobes want 0", seen); end
    if_a.en = 1'b1;
    wait_sreq(0);
  endtask

  task automatic test_reset_mid();
    int hs, hc, len;
    set_in(0, 8'h5A, 8'hA5);
    repeat (50) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({if_a.pwm_sine, if_a.pwm_cos, if_a.period_start, if_a.sample_req} !== 4'b0) begin
      n_bad++; $display("FAIL rst_mid_out: got %b want 0000",
        {if_a.pwm_sine, if_a.pwm_cos, if_a.period_start, if_a.sample_req});
    end
    n_cmp++;
    if ({dut_a.u_chan_s.r_duty, dut_a.u_chan_c.r_duty} !== 16'h0000) begin
      n_bad++; $display("FAIL rst_mid_duty: got %h want 0000",
        {dut_a.u_chan_s.r_duty, dut_a.u_chan_c.r_duty});
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (if_a.period_start !== 1'b1) begin
      n_bad++; $display("FAIL rst_reload_ps: got %b want 1", if_a.period_start);
    end
    n_cmp++;
    if ({dut_a.u_chan_s.r_duty, dut_a.u_chan_c.r_duty} !== 16'h5AA5) begin
      n_bad++; $display("FAIL rst_reload_duty: got %h want 5aa5",
        {dut_a.u_chan_s.r_duty, dut_a.u_chan_c.r_duty});
    end
    @(negedge clk);
    measure(0, -1, 8'h00, hs, hc, len);
    n_cmp++;
    if (hs !== 8'h5A || hc !== 8'hA5 || len !== PMAX) begin
      n_bad++; $display("FAIL rst_period: got s=%0d c=%0d len=%0d want 90 165 255", hs, hc, len);
    end
  endtask

  task automatic test_generator();
    int hs, hc, len, g0, lens_bad;
    g0 = gen_steps;
    lens_bad = 0;
    for (int p = 0; p < 5; p++) begin
      measure(0, -1, 8'h00, hs, hc, len);
      if (len != PMAX) lens_bad++;
    end
    n_cmp++;
    if (lens_bad !== 0) begin n_bad++; $display("FAIL gen_len: got %0d bad periods want 0", lens_bad); end
    n_cmp++;
    if (gen_steps - g0 !== 5) begin
      n_bad++; $display("FAIL gen_steps: got %0d want 5", gen_steps - g0);
    end
  endtask

  task automatic test_prescale();
    int hs, hc, len;
    logic [7:0] rc;
    if_a.en = 1'b0;
    set_in(1, 8'h01, 8'h80);
    if_b.en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({if_b.period_start, if_b.sample_req} !== 2'b10) begin
      n_bad++; $display("FAIL pre_ps: got %b want 10", {if_b.period_start, if_b.sample_req});
    end
    @(negedge clk);
    rc = 8'($urandom_range(1, 254));
    if_b.cos_u = rc;
    measure(1, 37, 8'h02, hs, hc, len);
    n_cmp++;
    if (hs !== 4 || hc !== 512 || len !== 1020) begin
      n_bad++; $display("FAIL pre_p0: got s=%0d c=%0d len=%0d want 4 512 1020", hs, hc, len);
    end
    measure(1, -1, 8'h00, hs, hc, len);
    n_cmp++;
    if (hs !== 8 || hc !== 4 * int'(rc) || len !== 1020) begin
      n_bad++; $display("FAIL pre_p1: got s=%0d c=%0d len=%0d want 8 %0d 1020", hs, hc, len, 4 * rc);
    end
  endtask

  initial begin
    logic [7:0] s0, c0;
    test_reset();
    test_basic();
    test_extremes();
    test_midchange(s0, c0);
    test_random(s0, c0);
    test_en_drop();
    test_wrap_vs_en();
    test_reset_mid();
    test_generator();
    test_prescale();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
